// File: rtl/apbgpu_pkg.sv
// Shared definitions for the APB GPU command queue: register indices,
// STATUS/CTRL bit positions and the command record.
package apbgpu_pkg;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_W   = 9;
  localparam int STAT_EMPTY_BIT = 9;
  localparam int STAT_FULL_BIT  = 10;
  localparam int STAT_OVF_BIT   = 11;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  localparam int CMD_OPCODE_W = 4;
  localparam int CMD_PARAM_W  = 25;

  typedef struct packed {
    logic [CMD_OPCODE_W-1:0] opcode;
    logic [CMD_PARAM_W-1:0]  parameters;
  } cmd_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO with flush; head data reads as zero while empty so the
// command fields downstream are clean when nothing is queued.
module gpu_cmd_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/apbgpu_cmdq.sv
// APB slave front end that queues GPU commands: CMD pushes, STATUS readback,
// CTRL flush / overflow clear, and wait-state or drop-with-error on a full queue.
module apbgpu_cmdq
  import apbgpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 4,
  parameter int PARAM_W  = 25,
  parameter int DEPTH    = 8,
  parameter int BLOCKING = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pAddr_i,
  input  logic [DATA_W-1:0]   pDataWrite_i,
  input  logic                pSel_i,
  input  logic                pEnable_i,
  input  logic                pWrite_i,
  output logic [DATA_W-1:0]   pDataRead_o,
  output logic                pReady_o,
  output logic                pSlvErr_o,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic [PARAM_W-1:0]  parameters_o
);

  localparam int CMD_W = OPCODE_W + PARAM_W;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic [1:0]        reg_idx;
  logic              access, done;
  logic              cmd_wr, cmd_rd, stat_wr, stat_rd, ctrl_wr, unmapped;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CMD_W-1:0]  push_data, head_data;
  logic              push, pop, flush, clr_ovf, drop;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] status_word;
  logic              err_cond;
  logic              unused_bits;

  assign reg_idx  = pAddr_i[3:2];
  assign access   = pSel_i & pEnable_i;
  assign cmd_wr   = access &  pWrite_i & (reg_idx == REG_CMD);
  assign cmd_rd   = access & ~pWrite_i & (reg_idx == REG_CMD);
  assign stat_wr  = access &  pWrite_i & (reg_idx == REG_STATUS);
  assign stat_rd  = access & ~pWrite_i & (reg_idx == REG_STATUS);
  assign ctrl_wr  = access &  pWrite_i & (reg_idx == REG_CTRL);
  assign unmapped = access & (reg_idx == 2'd3);

  // Full is taken from the registered count only: a pop this cycle does not
  // release a stalled write until the following cycle.
  assign pReady_o = ~((BLOCKING != 0) & cmd_wr & fifo_full);
  assign done     = access & pReady_o;

  assign drop     = (BLOCKING == 0) & cmd_wr & fifo_full;
  assign err_cond = unmapped | stat_wr | cmd_rd | drop;
  assign pSlvErr_o = done & err_cond;

  assign push    = done & cmd_wr & ~fifo_full;
  assign flush   = done & ctrl_wr & pDataWrite_i[CTRL_FLUSH_BIT];
  assign clr_ovf = done & ctrl_wr & pDataWrite_i[CTRL_CLR_OVF_BIT];
  assign pop     = cmd_valid_o & cmd_ready_i;

  assign push_data = {pDataWrite_i[DATA_W-1 -: OPCODE_W], pDataWrite_i[PARAM_W-1:0]};

  always_comb begin
    ovf_d = ovf_q;
    if (done & drop)  ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_COUNT_LSB +: CW] = fifo_count;
    status_word[STAT_EMPTY_BIT]       = fifo_empty;
    status_word[STAT_FULL_BIT]        = fifo_full;
    status_word[STAT_OVF_BIT]         = ovf_q;
  end

  assign pDataRead_o = stat_rd ? status_word : '0;

  gpu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign cmd_valid_o  = ~fifo_empty;
  assign opcode_o     = head_data[CMD_W-1 -: OPCODE_W];
  assign parameters_o = head_data[PARAM_W-1:0];

  assign unused_bits = ^{pAddr_i, pDataWrite_i};

endmodule

// File: tb/tb_apbgpu_cmdq.sv
// Self-checking bench for apbgpu_cmdq: a blocking and a dropping instance
// share one APB bus, checked against a queue-based reference model.
module tb_apbgpu_cmdq;
  import apbgpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        which = 1'b0;

  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, perr0, perr1, valid0, valid1;
  logic [3:0]  opc0, opc1;
  logic [24:0] par0, par1;

  logic [31:0] prdata_m;
  logic        pready_m, pslverr_m, valid_m;
  logic [3:0]  opc_m;
  logic [24:0] par_m;

  int total = 0;
  int bad   = 0;

  cmd_t q[$];
  logic ovf = 1'b0;

  always #5 clk = ~clk;

  apbgpu_cmdq #(.DATA_W(32), .OPCODE_W(4), .PARAM_W(25), .DEPTH(8), .BLOCKING(1)) u_blk (
    .clk(clk), .rst(rst), .pAddr_i(paddr), .pDataWrite_i(pwdata),
    .pSel_i(psel & ~which), .pEnable_i(penable), .pWrite_i(pwrite),
    .pDataRead_o(prdata0), .pReady_o(pready0), .pSlvErr_o(perr0),
    .cmd_valid_o(valid0), .cmd_ready_i(cmd_ready), .opcode_o(opc0), .parameters_o(par0)
  );

  apbgpu_cmdq #(.DATA_W(32), .OPCODE_W(4), .PARAM_W(25), .DEPTH(8), .BLOCKING(0)) u_drop (
    .clk(clk), .rst(rst), .pAddr_i(paddr), .pDataWrite_i(pwdata),
    .pSel_i(psel & which), .pEnable_i(penable), .pWrite_i(pwrite),
    .pDataRead_o(prdata1), .pReady_o(pready1), .pSlvErr_o(perr1),
    .cmd_valid_o(valid1), .cmd_ready_i(cmd_ready), .opcode_o(opc1), .parameters_o(par1)
  );

  assign prdata_m  = which ? prdata1 : prdata0;
  assign pready_m  = which ? pready1 : pready0;
  assign pslverr_m = which ? perr1   : perr0;
  assign valid_m   = which ? valid1  : valid0;
  assign opc_m     = which ? opc1    : opc0;
  assign par_m     = which ? par1    : par0;

  function automatic cmd_t split(input logic [31:0] d);
    cmd_t c;
    c.opcode     = d[31:28];
    c.parameters = d[24:0];
    return c;
  endfunction

  function automatic logic [31:0] mstat();
    logic [31:0] s;
    s = 32'(q.size());
    if (q.size() == 0) s = s | 32'h200;
    if (q.size() == 8) s = s | 32'h400;
    if (ovf)           s = s | 32'h800;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apb(input logic [31:0] addr, input logic [31:0] wd, input logic wr,
                     output logic [31:0] rd, output logic err, output int waits);
    step();
    psel = 1'b1; penable = 1'b0; paddr = addr; pwdata = wd; pwrite = wr;
    step();
    penable = 1'b1;
    #1;
    waits = 0;
    while (!pready_m && waits < 50) begin
      step();
      waits++;
    end
    total++;
    if (waits >= 50) begin
      bad++;
      $display("FAIL apb_timeout addr=%h got_waits=%0d exp_below=50", addr, waits);
    end
    rd  = prdata_m;
    err = pslverr_m;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_reset();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; cmd_ready = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    q.delete();
    ovf = 1'b0;
  endtask

  task automatic write_cmd(input logic [31:0] d, output logic err);
    logic [31:0] rd;
    int w;
    apb(32'h0, d, 1'b1, rd, err, w);
    if (q.size() < 8) q.push_back(split(d));
    else if (which) ovf = 1'b1;
  endtask

  task automatic check_status(input string name);
    logic [31:0] s;
    logic e;
    int w;
    apb(32'h4, 32'h0, 1'b0, s, e, w);
    total++;
    if (s !== mstat() || e !== 1'b0) begin
      bad++;
      $display("FAIL %s status got=%h err=%b exp=%h err=0", name, s, e, mstat());
    end
  endtask

  task automatic check_head(input string name);
    total++;
    if (q.size() == 0) begin
      if (valid_m !== 1'b0 || opc_m !== 4'h0 || par_m !== 25'h0) begin
        bad++;
        $display("FAIL %s head got v=%b op=%h par=%h exp v=0 op=0 par=0", name, valid_m, opc_m, par_m);
      end
    end else if (valid_m !== 1'b1 || opc_m !== q[0].opcode || par_m !== q[0].parameters) begin
      bad++;
      $display("FAIL %s head got v=%b op=%h par=%h exp v=1 op=%h par=%h",
               name, valid_m, opc_m, par_m, q[0].opcode, q[0].parameters);
    end
  endtask

  task automatic pop_one(input string name);
    check_head(name);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    #1;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && q.size() > 0; i++) pop_one(name);
    check_head({name, "_empty"});
  endtask

  task automatic test_reset();
    which = 1'b0;
    do_reset();
    total++;
    if (valid_m !== 1'b0 || opc_m !== 4'h0 || par_m !== 25'h0 || prdata_m !== 32'h0 ||
        pslverr_m !== 1'b0 || pready_m !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs got v=%b op=%h par=%h rd=%h err=%b rdy=%b exp 0/0/0/0/0/1",
               valid_m, opc_m, par_m, prdata_m, pslverr_m, pready_m);
    end
    check_status("reset");
  endtask

  task automatic test_single_push();
    logic e;
    which = 1'b0;
    do_reset();
    write_cmd(32'h91C71FCF, e);
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL single_push err got=%b exp=0", e); end
    check_head("single_push");
    check_status("single_push");
    drain("single_push");
  endtask

  task automatic test_blocking_full();
    logic e;
    logic [31:0] d9;
    cmd_t seen;
    which = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) write_cmd($urandom, e);
    check_status("blk_full");
    d9 = $urandom;
    step();
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwdata = d9; pwrite = 1'b1;
    step();
    penable = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (pready_m !== 1'b0) begin bad++; $display("FAIL blk_stall pready got=%b exp=0", pready_m); end
      step();
    end
    check_head("blk_stall_head");
    seen.opcode = opc_m; seen.parameters = par_m;
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    #1;
    void'(q.pop_front());
    total++;
    if (pready_m !== 1'b1) begin bad++; $display("FAIL blk_release pready got=%b exp=1", pready_m); end
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    q.push_back(split(d9));
    check_status("blk_after");
    drain("blk_order");

    // reset while a write is stalled: queue is discarded, transfer then completes
    for (int i = 0; i < 8; i++) write_cmd($urandom, e);
    d9 = $urandom;
    step();
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwdata = d9; pwrite = 1'b1;
    step();
    penable = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    q.delete();
    total++;
    if (pready_m !== 1'b1) begin bad++; $display("FAIL rst_stall pready got=%b exp=1", pready_m); end
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    q.push_back(split(d9));
    check_status("rst_stall");
    check_head("rst_stall");
  endtask

  task automatic test_nonblocking();
    logic e;
    which = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) write_cmd($urandom, e);
    write_cmd(32'hFFFFFFFF, e);
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL nb_overflow err got=%b exp=1", e); end
    check_status("nb_overflow");
    begin
      logic [31:0] rd;
      int w;
      apb(32'h8, 32'h2, 1'b1, rd, e, w);
      ovf = 1'b0;
    end
    check_status("nb_clear");
    drain("nb_order");
    which = 1'b0;
  endtask

  task automatic test_no_sel();
    which = 1'b0;
    do_reset();
    paddr = 32'h0; pwdata = 32'hFFFFFFFF;
    for (int i = 0; i < 8; i++) begin
      step();
      penable = i[0];
      pwrite  = i[1];
    end
    step();
    penable = 1'b0; pwrite = 1'b0;
    check_head("no_sel");
    check_status("no_sel");
  endtask

  task automatic test_flush_pop();
    logic e;
    which = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) write_cmd($urandom, e);
    step();
    psel = 1'b1; penable = 1'b0; paddr = 32'h8; pwdata = 32'h1; pwrite = 1'b1;
    step();
    penable = 1'b1;
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
    q.delete();
    check_head("flush_pop");
    check_status("flush_pop");
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs[$];
    logic [31:0] rd;
    logic e;
    int w;
    which = 1'b0;
    do_reset();
    cmd_ready = 1'b1;
    step();
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwdata = 32'hAAAAAAAA; pwrite = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (valid_m) obs.push_back(opc_m);
      if (penable) begin
        total++;
        if (pready_m !== 1'b1) begin bad++; $display("FAIL b2b pready got=%b exp=1", pready_m); end
      end
      case (c)
        0: penable = 1'b1;
        1: begin penable = 1'b0; pwdata = 32'h1C71C555; end
        2: penable = 1'b1;
        3: begin psel = 1'b0; penable = 1'b0; pwrite = 1'b0; end
        default: ;
      endcase
    end
    cmd_ready = 1'b0;
    total++;
    if (obs.size() != 2 || obs[0] !== split(32'hAAAAAAAA).opcode || obs[1] !== split(32'h1C71C555).opcode) begin
      bad++;
      $display("FAIL b2b_pops got_n=%0d first=%h exp_n=2 first=%h",
               obs.size(), (obs.size() > 0) ? obs[0] : 4'hx, split(32'hAAAAAAAA).opcode);
    end
    check_status("b2b");
    apb(32'hC, 32'h0, 1'b0, rd, e, w);
    total++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL unmapped_read got err=%b rd=%h exp err=1 rd=0", e, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic e;
    int w;
    which = 1'b0;
    do_reset();
    write_cmd(32'h3000_0042, e);
    apb(32'h4, 32'hFFFFFFFF, 1'b1, rd, e, w);
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL status_write err got=%b exp=1", e); end
    apb(32'h0, 32'h0, 1'b0, rd, e, w);
    total++;
    if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL cmd_read got err=%b rd=%h exp err=1 rd=0", e, rd); end
    apb(32'h8, 32'h0, 1'b0, rd, e, w);
    total++;
    if (e !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL ctrl_read got err=%b rd=%h exp err=0 rd=0", e, rd); end
    apb(32'hC, 32'h3, 1'b1, rd, e, w);
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL unmapped_write err got=%b exp=1", e); end
    check_status("errors");
    check_head("errors");
  endtask

  task automatic test_random();
    logic e;
    which = 1'b0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1: if (q.size() < 8) write_cmd($urandom, e); else pop_one("rand_pop");
        2: check_status("rand");
        default: if (q.size() > 0) pop_one("rand_pop"); else check_head("rand_idle");
      endcase
    end
    drain("rand_drain");
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_blocking_full();
    test_nonblocking();
    test_no_sel();
    test_flush_pop();
    test_back_to_back();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
